// File: rtl/counter_sequencer.sv
// Sequenced WIDTH-bit up/down counter with prescaler, one-shot/continuous modes,
// and start/stop/hold command handling (stop > start > hold).
module counter_sequencer #(
    parameter int WIDTH = 3,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic             do_start;
    logic             do_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pcnt_q  <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            load_q  <= '0;
            term_q  <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            load_q  <= load_d;
            term_q  <= term_d;
            div_q   <= div_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pcnt_d   = pcnt_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        load_d   = load_q;
        term_d   = term_q;
        div_d    = div_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        do_start = 1'b0;
        do_run   = 1'b0;

        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (!stop && start) begin
                    do_start = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (hold) begin
                    state_d = PAUSE;
                end else begin
                    do_run = 1'b1;
                end
            end
            PAUSE: begin
                // The release cycle is a run cycle, so holding N cycles costs exactly N cycles.
                if (stop) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (!hold) begin
                    state_d = RUN;
                    do_run  = 1'b1;
                end
            end
            DONE: begin
                pcnt_d = '0;
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    do_start = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_start) begin
            mode_d  = mode;
            dir_d   = dir;
            load_d  = load_val;
            term_d  = term_val;
            div_d   = div;
            count_d = load_val;
            pcnt_d  = '0;
            state_d = RUN;
        end

        if (do_run) begin
            if (pcnt_q == div_q) begin
                pcnt_d = '0;
                if (count_q == term_q) begin
                    if (mode_q) begin
                        count_d = load_q;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (dir_q) begin
                    count_d = count_q - 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer: one-shot, continuous,
// down-count rollover, hold timing, stop/terminal collision and async reset.
module tb_counter_sequencer;

    localparam int WIDTH = 3;
    localparam int DIV_W = 4;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             hold;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [1:0]       state;

    int vectors;
    int miscompares;

    counter_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .mode     (mode),
        .dir      (dir),
        .load_val (load_val),
        .term_val (term_val),
        .div      (div),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int exp_count, input logic [1:0] exp_state,
                            input logic exp_busy, input logic exp_done, input logic exp_wrap);
        checkOutput({tag, ".count"}, 32'(count), 32'(exp_count));
        checkOutput({tag, ".state"}, 32'(state), 32'(exp_state));
        checkOutput({tag, ".busy"},  32'(busy),  32'(exp_busy));
        checkOutput({tag, ".done"},  32'(done),  32'(exp_done));
        checkOutput({tag, ".wrap"},  32'(wrap),  32'(exp_wrap));
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic h, input logic m,
                                 input logic d, input int lv, input int tv, input int dv);
        start    = s;
        stop     = sp;
        hold     = h;
        mode     = m;
        dir      = d;
        load_val = WIDTH'(lv);
        term_val = WIDTH'(tv);
        div      = DIV_W'(dv);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    int exp_cnt2[9]  = '{6, 7, 0, 1, 6, 7, 0, 1, 6};
    int exp_wrp2[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_cnt3[13] = '{1, 1, 1, 0, 0, 0, 7, 7, 7, 6, 6, 6, 6};

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idleInputs();

        // Reset values
        #1 rst = 1'b1;
        #2;
        checkAll("reset", 0, S_IDLE, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        checkAll("reset_held", 0, S_IDLE, 1'b0, 1'b0, 1'b0);

        // One-shot up 2 -> 5, div 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 5, 0);
        cycle();
        checkAll("t1_e0", 2, S_RUN, 1'b1, 1'b0, 1'b0);
        idleInputs();
        cycle(); checkAll("t1_e1", 3, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t1_e2", 4, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t1_e3", 5, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t1_e4", 5, S_DONE, 1'b0, 1'b1, 1'b0);
        cycle(); checkAll("t1_e5", 5, S_DONE, 1'b0, 1'b0, 1'b0);

        // Continuous up 6 -> 1 with reload, started from DONE
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1, 0);
        for (int i = 0; i < 9; i++) begin
            cycle();
            checkAll($sformatf("t2_e%0d", i), exp_cnt2[i], S_RUN, 1'b1, 1'b0, exp_wrp2[i][0]);
            idleInputs();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        cycle();
        checkAll("t2_stop", 6, S_IDLE, 1'b0, 1'b0, 1'b0);

        // Down one-shot 1 -> 6 with div 2, rollover 0 -> 7 is silent
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 6, 2);
        for (int i = 0; i < 13; i++) begin
            cycle();
            checkAll($sformatf("t3_e%0d", i), exp_cnt3[i], (i == 12) ? S_DONE : S_RUN,
                     (i != 12), (i == 12), 1'b0);
            idleInputs();
        end

        // Hold for 5 cycles mid-count with div 3
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 7, 3);
        cycle();
        checkAll("t4_e0", 0, S_RUN, 1'b1, 1'b0, 1'b0);
        idleInputs();
        cycle();
        cycle();
        checkAll("t4_e2", 0, S_RUN, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 3; i < 8; i++) begin
            cycle();
            checkAll($sformatf("t4_e%0d", i), 0, S_PAUSE, 1'b1, 1'b0, 1'b0);
        end
        idleInputs();
        cycle(); checkAll("t4_e8", 0, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t4_e9", 1, S_RUN, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        cycle(); checkAll("t4_stop", 1, S_IDLE, 1'b0, 1'b0, 1'b0);

        // Stop coincident with the terminal tick, then start together with stop
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 5, 1);
        cycle(); checkAll("t5_e0", 4, S_RUN, 1'b1, 1'b0, 1'b0);
        idleInputs();
        cycle(); checkAll("t5_e1", 4, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t5_e2", 5, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t5_e3", 5, S_RUN, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        cycle(); checkAll("t5_e4", 5, S_IDLE, 1'b0, 1'b0, 1'b0);
        idleInputs();
        cycle(); checkAll("t5_e5", 5, S_IDLE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 3, 0);
        cycle(); checkAll("t5_both", 5, S_IDLE, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, then a normal restart
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 7, 0);
        cycle(); checkAll("t6_e0", 2, S_RUN, 1'b1, 1'b0, 1'b0);
        idleInputs();
        cycle(); checkAll("t6_e1", 3, S_RUN, 1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        checkAll("t6_async", 0, S_IDLE, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 4, 0);
        cycle(); checkAll("t6_inrst", 0, S_IDLE, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(); checkAll("t6_r0", 3, S_RUN, 1'b1, 1'b0, 1'b0);
        idleInputs();
        cycle(); checkAll("t6_r1", 4, S_RUN, 1'b1, 1'b0, 1'b0);
        cycle(); checkAll("t6_r2", 4, S_DONE, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller-plus-datapath that sequences a WIDTH-bit binary counter: loads it, steps it up or down at a programmable rate, and stops or reloads at a programmed terminal value.
- Replaces free-running ripple counting wherever software-style control is needed: start/stop/hold, one-shot versus continuous operation, and done/wrap events.
- Fully synchronous to a single clock, with no derived clocks.

Parameters:
- WIDTH, 3, counter width in bits.
- DIV_W, 4, width of the prescaler divide value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled command: load and run.
- stop  input  1  abort to IDLE; highest priority.
- hold  input  1  pause counting while high (RUN only).
- mode  input  1  0 = one-shot, 1 = continuous; latched on start.
- dir  input  1  0 = up, 1 = down; latched on start.
- load_val  input  WIDTH  start value; latched on start.
- term_val  input  WIDTH  terminal value; latched on start.
- div  input  DIV_W  tick every div+1 cycles; latched on start.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse on entry to DONE.
- wrap  output  1  one-cycle pulse on continuous-mode reload.
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; count=0; busy=0; done=0; wrap=0.
  - Prescaler and all latched configuration = 0.
- Command priority each cycle: stop > start > hold.
- Prescaler pcnt (DIV_W bits):
  - Cleared on start.
  - In RUN: tick = (pcnt==div_l). On tick pcnt<=0, else pcnt<=pcnt+1.
  - div_l=0 gives a tick every RUN cycle.
  - Frozen in PAUSE; cleared in IDLE and DONE.
- Tick action (RUN only):
  - If count==term_l and mode_l=0: count holds; next state DONE; done=1 for the following cycle.
  - If count==term_l and mode_l=1: count<=load_l; wrap=1 for one cycle; stay in RUN.
  - Otherwise: count<=count+1 (dir_l=0) or count-1 (dir_l=1), modulo 2^WIDTH. For WIDTH=3: 7 -> 0 up, 0 -> 7 down, with no event.
- IDLE:
  - start: latch mode, dir, load_val, term_val, div; count<=load_val; go to RUN.
  - Otherwise hold; count retains its last value.
- RUN:
  - stop: go to IDLE, count retained.
  - start is ignored, with no relatch.
  - hold (and no stop): go to PAUSE, with no tick that cycle.
  - Otherwise apply tick logic.
- PAUSE:
  - stop: go to IDLE.
  - hold low: go to RUN, with the prescaler resuming from its frozen value.
  - start is ignored.
- DONE:
  - count holds at term_l.
  - start: relatch and go to RUN, exactly as from IDLE.
  - stop: go to IDLE.
  - Otherwise remain in DONE.
- Timing:
  - First step occurs div_l+1 cycles after the RUN entry edge.
  - One-shot total from start sample to done pulse = (steps+1)·(div_l+1) cycles, where steps = distance load->term in dir_l, modulo 2^WIDTH.
- Simultaneous events:
  - Tick coincident with stop: stop wins, with no step, done or wrap.
  - Tick coincident with hold: hold wins.
- Pulse widths: done and wrap are never high more than one consecutive cycle, except wrap in continuous mode with load==term and div=0, which pulses every cycle.
- busy = (state==RUN || state==PAUSE), registered with state.
- Reset asserted mid-operation: all outputs return to reset values immediately; no command is honoured until rst is deasserted.

Test Plan:
- Reset, then start with mode=0, dir=0, load=2, term=5, div=0 -> count 2,3,4,5; done pulses once 4 cycles after RUN entry; state=DONE with count held at 5.
- Continuous up with load=6, term=1, div=0 -> count 6,7,0,1,6,7…; wrap pulses one cycle on each 1->6 reload; busy stays 1.
- Down one-shot with load=1, term=6, div=2 -> count 1,0,7,6, each step 3 cycles apart; done after 12 cycles; no done on the 0->7 rollover.
- hold asserted for 5 cycles mid-count with div=3 -> state=PAUSE and count frozen; after release the remaining prescaler cycles elapse before the next step; total added latency = 5 cycles.
- stop asserted in the same cycle as a terminal tick -> IDLE, count unchanged, done=0; start in the same cycle as stop -> IDLE.
- rst pulsed asynchronously mid-RUN (between clock edges) -> count=0 and state=IDLE immediately; a subsequent start with load=3 resumes normally.
